// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU with an iterative shift-add multiplier and restoring divider.
// Define ALU_DIV_EN to build the divider; without it DIVU/REMU pass A in a single cycle.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero
);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpXor   = 4'b0011;
  localparam logic [3:0] OpSll   = 4'b0100;
  localparam logic [3:0] OpSrl   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSra   = 4'b0111;
  localparam logic [3:0] OpSlt   = 4'b1000;
  localparam logic [3:0] OpSltu  = 4'b1001;
  localparam logic [3:0] OpMul   = 4'b1010;
  localparam logic [3:0] OpMulhu = 4'b1011;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OpDivu  = 4'b1100;
  localparam logic [3:0] OpRemu  = 4'b1101;
`endif

  localparam logic [SHW:0] CntInit = (SHW+1)'(WIDTH-1);
  localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
`ifdef ALU_DIV_EN
    StDiv  = 2'd2,
`endif
    StDone = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               issue_q, issue_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   mul_res;

  assign shamt  = b_q[SHW-1:0];
  assign is_mul = (op_q == OpMul) || (op_q == OpMulhu);

  always_comb begin
    alu_res = a_q;
    case (op_q)
      OpAnd:   alu_res = a_q & b_q;
      OpOr:    alu_res = a_q | b_q;
      OpAdd:   alu_res = a_q + b_q;
      OpXor:   alu_res = a_q ^ b_q;
      OpSll:   alu_res = a_q << shamt;
      OpSrl:   alu_res = a_q >> shamt;
      OpSub:   alu_res = a_q - b_q;
      OpSra:   alu_res = WIDTH'($signed(a_q) >>> shamt);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      default: alu_res = a_q;
    endcase
  end

  // Multiplier sits in the low half of prod and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_res  = op_q[0] ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];

`ifdef ALU_DIV_EN
  logic               is_div;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_res;

  assign is_div = (op_q == OpDivu) || (op_q == OpRemu);

  // prod holds {remainder, dividend/quotient}; a borrow in bit WIDTH means restore.
  assign div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign div_res   = op_q[0] ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      StIdle: begin
        // issue_q marks the cycle after accept where latched operands are dispatched.
        if (issue_q) begin
          issue_d = 1'b0;
          if (is_mul) begin
            state_d = StMul;
            cnt_d   = CntInit;
            prod_d  = {{WIDTH{1'b0}}, b_q};
`ifdef ALU_DIV_EN
          end else if (is_div) begin
            state_d = StDiv;
            cnt_d   = CntInit;
            prod_d  = {{WIDTH{1'b0}}, a_q};
`endif
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end else if (in_valid) begin
          issue_d = 1'b1;
          op_d    = op;
          a_d     = A;
          b_d     = B;
        end
      end
      StMul: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == '0) begin
          state_d  = StDone;
          cnt_d    = '0;
          result_d = mul_res;
          zero_d   = (mul_res == '0);
        end
      end
`ifdef ALU_DIV_EN
      StDiv: begin
        prod_d = div_next;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == '0) begin
          state_d  = StDone;
          cnt_d    = '0;
          result_d = div_res;
          zero_d   = (div_res == '0);
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      issue_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == StIdle) && !issue_q;
  assign out_valid  = (state_q == StDone);
  assign ALU_result = result_q;
  assign zero       = zero_q;

endmodule
